pcm_fetch: RTL

PCM_FETCH -- requirements
Module: pcm_fetch

---
 rtl/pcm_fetch.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pcm_fetch.sv
`timescale 1ns/1ps
// PCM playback fetcher: pulls stereo frames from SPI flash into a small FIFO
// and releases one offset-binary frame per DIV clock cycles.
module pcm_fetch #(
    parameter logic [23:0] BASE_ADDR  = 24'h000000,
    parameter logic [23:0] SIZE_BYTES = 24'd960000,
    parameter int          DEPTH      = 4,
    parameter int          DIV        = 1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    output logic                     flash_valid,
    output logic [23:0]              flash_addr,
    input  logic                     flash_ready,
    input  logic [31:0]              flash_rdata,
    output logic                     sample_stb,
    output logic [15:0]              sample_l,
    output logic [15:0]              sample_r,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [0:0]    IDLE      = 1'b0;
    localparam logic [0:0]    REQ       = 1'b1;
    localparam logic [23:0]   LAST_ADDR = BASE_ADDR + SIZE_BYTES - 24'd4;
    localparam logic [LW-1:0] FULL      = LW'(DEPTH);
    localparam logic [TW-1:0] TMAX      = TW'(DIV - 1);

    logic [0:0]    state_q, state_d;
    logic [23:0]   addr_q, addr_d;
    logic [23:0]   next_q, next_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          stb_q, stb_d;
    logic [15:0]   l_q, l_d;
    logic [15:0]   r_q, r_d;
    logic          under_q, under_d;
    logic [LW-1:0] level_q, level_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [31:0]   mem_q [DEPTH];

    logic push_s;
    logic tick_s;
    logic pop_s;

    assign push_s = (state_q == REQ) && flash_ready;
    assign tick_s = (timer_q == TMAX);
    // Popping needs a frame already present: a same-cycle push into an empty FIFO is kept, not forwarded.
    assign pop_s  = tick_s && (level_q != {LW{1'b0}});

    // Next-state logic for the fetch FSM, frame timer and FIFO bookkeeping.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        next_d  = next_q;
        timer_d = timer_q;
        stb_d   = tick_s;
        l_d     = l_q;
        r_d     = r_q;
        under_d = under_q;
        level_d = level_q;
        wr_d    = wr_q;
        rd_d    = rd_q;

        case (state_q)
            IDLE: begin
                if (enable && (level_q < FULL)) begin
                    state_d = REQ;
                    addr_d  = next_q;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (flash_ready) begin
                    state_d = IDLE;
                    next_d  = (next_q == LAST_ADDR) ? BASE_ADDR : next_q + 24'd4;
                end else begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!enable) begin
            timer_d = {TW{1'b0}};
        end else if (tick_s) begin
            timer_d = {TW{1'b0}};
        end else begin
            timer_d = timer_q + TW'(1'b1);
        end

        if (pop_s) begin
            l_d  = mem_q[rd_q][31:16];
            r_d  = mem_q[rd_q][15:0];
            rd_d = rd_q + PW'(1'b1);
        end else if (tick_s) begin
            under_d = 1'b1;
        end else begin
            under_d = under_q;
        end

        if (push_s) begin
            wr_d = wr_q + PW'(1'b1);
        end else begin
            wr_d = wr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1'b1);
            2'b01:   level_d = level_q - LW'(1'b1);
            default: level_d = level_q;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= BASE_ADDR;
            next_q  <= BASE_ADDR;
            timer_q <= {TW{1'b0}};
            stb_q   <= 1'b0;
            l_q     <= 16'h8000;
            r_q     <= 16'h8000;
            under_q <= 1'b0;
            level_q <= {LW{1'b0}};
            wr_q    <= {PW{1'b0}};
            rd_q    <= {PW{1'b0}};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            next_q  <= next_d;
            timer_q <= timer_d;
            stb_q   <= stb_d;
            l_q     <= l_d;
            r_q     <= r_d;
            under_q <= under_d;
            level_q <= level_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    // Frame storage, converted to offset-binary on the way in.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_q] <= {flash_rdata[31:16] ^ 16'h8000, flash_rdata[15:0] ^ 16'h8000};
        end
    end

    assign flash_valid = (state_q == REQ);
    assign flash_addr  = addr_q;
    assign sample_stb  = stb_q;
    assign sample_l    = l_q;
    assign sample_r    = r_q;
    assign underrun    = under_q;
    assign level       = level_q;
endmodule
